// File: rtl/mem8x8_ctrl.sv
// Sequencer and two-port round-robin arbiter for an unclocked NAND-latch bitcell array.
// Each access runs SETUP, STROBE (STROBE_CYCLES long) and HOLD so sel never moves while rw/data do.
module mem8x8_ctrl #(
  parameter int unsigned ROWS          = 8,
  parameter int unsigned COLS          = 8,
  parameter int unsigned STROBE_CYCLES = 2,
  localparam int unsigned AW           = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [2*AW-1:0]   i_addr,
  input  logic [2*COLS-1:0] i_wdata,
  output logic [1:0]        o_ack,
  output logic [COLS-1:0]   o_rdata,
  output logic              o_busy,
  output logic [ROWS-1:0]   o_row_sel,
  output logic              o_arr_rw,
  output logic [COLS-1:0]   o_arr_inp,
  input  logic [COLS-1:0]   i_arr_outp
);

  localparam int unsigned CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_last;
  logic            r_gnt;
  logic [AW-1:0]   r_addr;
  logic [1:0]      r_ack;
  logic [COLS-1:0] r_rdata;
  logic            r_busy;
  logic [ROWS-1:0] r_row_sel;
  logic            r_arr_rw;
  logic [COLS-1:0] r_arr_inp;

  logic            w_any;
  logic            w_gnt;
  logic            w_we_g;
  logic [AW-1:0]   w_addr_g;
  logic [COLS-1:0] w_wdata_g;
  logic [ROWS-1:0] w_row_dec;
  logic            w_addr_ok;

  // On contention the port that was not served last wins.
  assign w_any     = |i_req;
  assign w_gnt     = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign w_we_g    = w_gnt ? i_we[1] : i_we[0];
  assign w_addr_g  = w_gnt ? i_addr[AW +: AW] : i_addr[0 +: AW];
  assign w_wdata_g = w_gnt ? i_wdata[COLS +: COLS] : i_wdata[0 +: COLS];

  // Out-of-range addresses decode to no row at all.
  always_comb begin
    w_row_dec = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (r_addr == AW'(r)) w_row_dec[r] = 1'b1;
    end
  end

  assign w_addr_ok = |w_row_dec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_addr    <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_row_sel <= '0;
      r_arr_rw  <= 1'b0;
      r_arr_inp <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_last    <= w_gnt;
            r_addr    <= w_addr_g;
            r_arr_rw  <= w_we_g;
            r_arr_inp <= w_we_g ? w_wdata_g : '0;
            r_busy    <= 1'b1;
            r_state   <= StSetup;
          end
        end
        StSetup: begin
          r_row_sel <= w_row_dec;
          r_cnt     <= CW'(STROBE_CYCLES - 1);
          r_state   <= StStrobe;
        end
        StStrobe: begin
          if (r_cnt == '0) begin
            r_row_sel <= '0;
            r_ack     <= r_gnt ? 2'b10 : 2'b01;
            if (!r_arr_rw) r_rdata <= w_addr_ok ? i_arr_outp : '0;
            r_state   <= StHold;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StHold: begin
          r_arr_rw  <= 1'b0;
          r_arr_inp <= '0;
          r_busy    <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ack     = r_ack;
  assign o_rdata   = r_rdata;
  assign o_busy    = r_busy;
  assign o_row_sel = r_row_sel;
  assign o_arr_rw  = r_arr_rw;
  assign o_arr_inp = r_arr_inp;

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Directed bench for mem8x8_ctrl driving a behavioural 8x8 latch array.
module tb_mem8x8_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] i_req = '0;
  logic [1:0] i_we = '0;
  logic [5:0] i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic [1:0] o_ack;
  logic [7:0] o_rdata;
  logic       o_busy;
  logic [7:0] o_row_sel;
  logic       o_arr_rw;
  logic [7:0] o_arr_inp;
  logic [7:0] i_arr_outp;

  int checks = 0;
  int failures = 0;

  mem8x8_ctrl #(
    .ROWS(8),
    .COLS(8),
    .STROBE_CYCLES(2)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .i_we(i_we),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .o_ack(o_ack),
    .o_rdata(o_rdata),
    .o_busy(o_busy),
    .o_row_sel(o_row_sel),
    .o_arr_rw(o_arr_rw),
    .o_arr_inp(o_arr_inp),
    .i_arr_outp(i_arr_outp)
  );

  always #5 i_clk = ~i_clk;

  // Unclocked cell rows: transparent while selected for write.
  logic [7:0] cells [8];
  for (genvar r = 0; r < 8; r++) begin : g_row
    always_latch begin
      if (o_row_sel[r] && o_arr_rw) cells[r] <= o_arr_inp;
    end
  end

  always_comb begin
    i_arr_outp = '0;
    for (int r = 0; r < 8; r++) begin
      if (o_row_sel[r]) i_arr_outp = i_arr_outp | cells[r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Per-cycle protocol checker.
  logic       chk_en = 1'b0;
  logic       rst_edge = 1'b0;
  logic [7:0] prev_sel = '0;
  logic       prev_rw = 1'b0;
  logic [7:0] prev_inp = '0;

  always @(posedge i_clk) rst_edge <= i_rst;

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("row_sel_onehot", 32'($countones(o_row_sel) <= 1), 32'd1);
      chk("ack_onehot", 32'($countones(o_ack) <= 1), 32'd1);
      if (!rst_edge && (o_row_sel != 0 || prev_sel != 0))
        chk("arr_stable", {23'd0, o_arr_rw, o_arr_inp}, {23'd0, prev_rw, prev_inp});
    end
    prev_sel = o_row_sel;
    prev_rw  = o_arr_rw;
    prev_inp = o_arr_inp;
  end

  task automatic access(input int p, input logic we, input logic [2:0] a, input logic [7:0] d,
                        output int lat, output int strobes, output logic [7:0] rd);
    logic [7:0] exp_sel;
    exp_sel = 8'd1 << a;
    for (int n = 0; n < 20 && o_busy; n++) tick();
    i_req[p]          = 1'b1;
    i_we[p]           = we;
    i_addr[p*3 +: 3]  = a;
    i_wdata[p*8 +: 8] = d;
    lat = 0;
    strobes = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (o_row_sel == exp_sel) strobes++;
      if (o_ack[p]) break;
    end
    rd = o_rdata;
    i_req[p] = 1'b0;
  endtask

  initial begin
    int lat, strobes, first0, first1, n;
    int seq [3];
    logic [7:0] rd;

    // Reset
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_row_sel", o_row_sel, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_arr_rw", o_arr_rw, 0);
    chk_en = 1'b1;

    // Write then read, port 0
    access(0, 1'b1, 3'd3, 8'hA5, lat, strobes, rd);
    chk("wr_latency", lat, 4);
    chk("wr_strobe_cycles", strobes, 2);
    access(0, 1'b0, 3'd3, 8'h00, lat, strobes, rd);
    chk("rd_row3", rd, 8'hA5);
    chk("rd_latency", lat, 4);
    access(0, 1'b1, 3'd6, 8'h5A, lat, strobes, rd);
    chk("rdata_kept_on_write", rd, 8'hA5);

    // Both ports request right after reset
    i_rst = 1'b1;
    tick();
    tick();
    i_rst   = 1'b0;
    i_we    = 2'b11;
    i_addr  = {3'd1, 3'd0};
    i_wdata = {8'h22, 8'h11};
    i_req   = 2'b11;
    first0 = -1;
    first1 = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (o_ack[0] && first0 < 0) begin
        first0 = c;
        i_req[0] = 1'b0;
      end
      if (o_ack[1] && first1 < 0) begin
        first1 = c;
        i_req[1] = 1'b0;
      end
      if (first0 >= 0 && first1 >= 0) break;
    end
    chk("both_ack0_cycle", first0, 3);
    chk("both_ack1_cycle", first1, 8);
    access(0, 1'b0, 3'd0, 8'h00, lat, strobes, rd);
    chk("rd_row0", rd, 8'h11);
    access(1, 1'b0, 3'd1, 8'h00, lat, strobes, rd);
    chk("rd_row1_p1", rd, 8'h22);

    // Port 1 holds req, port 0 joins: grants must alternate
    for (int k = 0; k < 20 && o_busy; k++) tick();
    i_we[1] = 1'b1;
    i_addr[5:3] = 3'd4;
    i_wdata[15:8] = 8'h44;
    i_req[1] = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      tick();
      if (o_ack[1]) begin
        seq[n] = 1;
        n++;
        if (n == 1) begin
          i_we[0] = 1'b1;
          i_addr[2:0] = 3'd5;
          i_wdata[7:0] = 8'h55;
          i_req[0] = 1'b1;
        end
      end else if (o_ack[0]) begin
        seq[n] = 0;
        n++;
        i_req[0] = 1'b0;
      end
    end
    i_req = 2'b00;
    chk("rr_grants", n, 3);
    chk("rr_first", seq[0], 1);
    chk("rr_second", seq[1], 0);
    chk("rr_third", seq[2], 1);
    access(0, 1'b0, 3'd5, 8'h00, lat, strobes, rd);
    chk("rd_row5", rd, 8'h55);
    access(1, 1'b0, 3'd4, 8'h00, lat, strobes, rd);
    chk("rd_row4", rd, 8'h44);

    // Reset during STROBE
    for (int k = 0; k < 20 && o_busy; k++) tick();
    i_we[0] = 1'b1;
    i_addr[2:0] = 3'd2;
    i_wdata[7:0] = 8'hFF;
    i_req[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_row_sel != 0) break;
    end
    chk("strobe_reached", o_row_sel, 8'h04);
    i_rst = 1'b1;
    i_req = 2'b00;
    tick();
    chk("midrst_row_sel", o_row_sel, 0);
    chk("midrst_ack", o_ack, 0);
    chk("midrst_busy", o_busy, 0);
    i_rst = 1'b0;
    access(0, 1'b1, 3'd7, 8'h3C, lat, strobes, rd);
    chk("post_rst_wr_latency", lat, 4);
    access(0, 1'b0, 3'd7, 8'h00, lat, strobes, rd);
    chk("rd_row7", rd, 8'h3C);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
